pc_fetch_stage: RTL and testbench
=================================

# pc_fetch_stage

Program-counter and fetch stage of the RISC-V core, directly upstream of the instruction memory wrapper. It owns the PC, drives the instruction address, captures the returned instruction word into the IF/ID register with a valid/ready handshake toward decode, applies branch/jump redirects from execute, and halts on illegal fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FETCH_LIMIT, 32'h0000_0400, first byte address outside instruction memory.
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high; same net as the instruction memory reset.
- inst_add  out  32  fetch byte address to instruction memory; equals the PC register.
- inst_code  in  32  instruction word from memory, combinationally valid in the same cycle as inst_add.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_target  in  32  new PC when redirect_valid is high.
- id_ready  in  1  decode can accept the IF/ID contents.
- id_valid  out  1  IF/ID holds a valid instruction.
- id_inst  out  32  captured instruction.
- id_pc  out  32  address of id_inst.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- fetch_fault  out  1  sticky illegal-fetch flag.
- halted  out  1  high in HALT state.

## Operation
- Reset values: pc = RESET_PC, state = BOOT, id_valid = 0, id_inst = 32'h0000_0013 (NOP), id_pc = 0, id_pc_plus4 = 4, fetch_fault = 0, halted = 0.
- States: BOOT, RUN, HALT. Only reset exits HALT.
- BOOT: lasts exactly one cycle; no capture, pc held (lets instruction memory leave reset); -> RUN.
- RUN, priority order per cycle:
  - redirect_valid = 1: id_valid <= 0 (wrong-path instruction discarded, regardless of id_ready). If redirect_target[1:0] != 0 or redirect_target >= FETCH_LIMIT: pc <= redirect_target, fetch_fault <= 1, -> HALT. Else pc <= redirect_target.
  - advance = !id_valid || id_ready. If advance and (pc[1:0] != 0 or pc >= FETCH_LIMIT): no capture, id_valid <= 0 if id_ready else held, fetch_fault <= 1, -> HALT.
  - advance, legal pc: id_inst <= inst_code, id_pc <= pc, id_pc_plus4 <= pc + 4, id_valid <= 1, pc <= pc + 4.
  - not advance: pc and all id_* held.
- HALT: pc held; redirect_valid ignored; no new captures; if id_valid && id_ready, id_valid <= 0 (drain); halted = 1.
- PC arithmetic: 32-bit, pc + 4 wraps 32'hFFFF_FFFC -> 0 (reachable only if FETCH_LIMIT permits).
- Handshake: a transfer occurs on a rising edge with id_valid && id_ready; id_* must not change while id_valid && !id_ready except via redirect flush.

## Timing
- inst_add = pc combinationally from the register; zero added delay.
- Fetch latency: instruction at address A appears on id_inst the edge after inst_add = A and advance.
- After reset release: edge 1 BOOT->RUN, edge 2 first capture; id_valid first high after edge 2.
- Redirect penalty: redirect sampled at edge N; inst_add = target after N; target instruction valid on id after N+1; one bubble.
- Sustained throughput with id_ready = 1: one instruction per cycle.
- Reset asserted in any state/cycle overrides everything next edge, including mid-stall and HALT.

## Test plan
- Reset, RESET_PC = 0, memory returns word = address, id_ready = 1 -> inst_add 0,4,8,…; id_valid high after edge 2 with id_inst = 0, id_pc = 0, id_pc_plus4 = 4; then one instruction per cycle.
- id_ready low 3 cycles with id_valid = 1, id_pc = 8 -> id_inst/id_pc stable at 8, inst_add held at 12; release -> id_pc = 12 next edge.
- redirect_valid with target 0x40 while id_ready = 0 -> next cycle id_valid = 0, inst_add = 0x40; following cycle id_pc = 0x40, id_valid = 1.
- redirect to 0x42 -> fetch_fault = 1, halted = 1, inst_add = 0x42, id_valid = 0; later redirect to 0x80 ignored.
- FETCH_LIMIT = 0x10, id_ready = 1 -> id_pc 0,4,8,0xC delivered, then fetch_fault = 1, halted = 1, inst_add = 0x10, id_valid drops after 0xC consumed.
- Reset asserted in HALT -> next edge state BOOT, fetch_fault = 0, halted = 0, inst_add = RESET_PC, id_valid = 0.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: PC register, instruction fetch, IF/ID handshake, redirect and illegal-fetch halt.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] FETCH_LIMIT = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_add,
  input  logic [31:0] inst_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic        halted
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, idpc_q, idpc_d, plus4_q, plus4_d;
  logic        valid_q, valid_d, fault_q, fault_d, halted_q;
  logic        advance, pc_bad, tgt_bad;
  assign advance = !valid_q || id_ready;
  assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= FETCH_LIMIT);
  assign tgt_bad = (redirect_target[1:0] != 2'b00) || (redirect_target >= FETCH_LIMIT);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    idpc_d  = idpc_q;
    plus4_d = plus4_q;
    fault_d = fault_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (redirect_valid) begin
        valid_d = 1'b0;
        pc_d    = redirect_target;
        fault_d = fault_q | tgt_bad;
        state_d = tgt_bad ? HALT : RUN;
      end else if (advance && pc_bad) begin
        valid_d = id_ready ? 1'b0 : valid_q;
        fault_d = 1'b1;
        state_d = HALT;
      end else if (advance) begin
        inst_d  = inst_code;
        idpc_d  = pc_q;
        plus4_d = pc_q + 32'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end
    end else begin
      valid_d = (valid_q && id_ready) ? 1'b0 : valid_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      inst_q   <= 32'h0000_0013;
      idpc_q   <= 32'h0000_0000;
      plus4_q  <= 32'h0000_0004;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      idpc_q   <= idpc_d;
      plus4_q  <= plus4_d;
      fault_q  <= fault_d;
      halted_q <= (state_d == HALT);
    end
  end
  assign inst_add    = pc_q;
  assign id_valid    = valid_q;
  assign id_inst     = inst_q;
  assign id_pc       = idpc_q;
  assign id_pc_plus4 = plus4_q;
  assign fetch_fault = fault_q;
  assign halted      = halted_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed bench for pc_fetch_stage; memory returns word = address.
module tb_pc_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, redirect_valid, id_ready;
  logic [31:0] redirect_target, inst_add, inst_code, id_inst, id_pc, id_pc_plus4;
  logic        id_valid, fetch_fault, halted;
  logic        reset2, redirect_valid2, id_ready2;
  logic [31:0] redirect_target2, inst_add2, inst_code2, id_inst2, id_pc2, id_pc_plus42;
  logic        id_valid2, fetch_fault2, halted2;
  int n_checks = 0;
  int n_fails  = 0;
  assign inst_code  = inst_add;
  assign inst_code2 = inst_add2;
  pc_fetch_stage dut (
    .clk(clk), .reset(reset), .inst_add(inst_add), .inst_code(inst_code),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault), .halted(halted)
  );
  pc_fetch_stage #(.FETCH_LIMIT(32'h0000_0010)) dut2 (
    .clk(clk), .reset(reset2), .inst_add(inst_add2), .inst_code(inst_code2),
    .redirect_valid(redirect_valid2), .redirect_target(redirect_target2),
    .id_ready(id_ready2), .id_valid(id_valid2), .id_inst(id_inst2), .id_pc(id_pc2),
    .id_pc_plus4(id_pc_plus42), .fetch_fault(fetch_fault2), .halted(halted2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] add);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_add"}, inst_add, add);
  endtask
  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; id_ready = 1'b1;
    reset2 = 1'b1; redirect_valid2 = 1'b0; redirect_target2 = '0; id_ready2 = 1'b1;
    step();
    chk("rst_add", inst_add, 32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'h13);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_plus4", id_pc_plus4, 32'h4);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    step();
    chk_id("boot", 1'b0, 32'h0, 32'h0);
    step();
    chk_id("cap0", 1'b1, 32'h0, 32'h4);
    chk("cap0_inst", id_inst, 32'h0);
    chk("cap0_plus4", id_pc_plus4, 32'h4);
    step();
    chk_id("cap4", 1'b1, 32'h4, 32'h8);
    step();
    chk_id("cap8", 1'b1, 32'h8, 32'hC);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 1'b1, 32'h8, 32'hC);
      chk("stall_inst", id_inst, 32'h8);
    end
    id_ready = 1'b1;
    step();
    chk_id("release", 1'b1, 32'hC, 32'h10);
    chk("release_plus4", id_pc_plus4, 32'h10);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_add", inst_add, 32'h40);
    redirect_valid = 1'b0; id_ready = 1'b1;
    step();
    chk_id("tgt", 1'b1, 32'h40, 32'h44);
    chk("tgt_inst", id_inst, 32'h40);
    chk("tgt_plus4", id_pc_plus4, 32'h44);
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    chk_id("mis", 1'b0, 32'h40, 32'h42);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    redirect_target = 32'h80;
    step();
    chk_id("halt_ign", 1'b0, 32'h40, 32'h42);
    chk("halt_ign_halted", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b0;
    reset = 1'b1;
    step();
    chk_id("rst_halt", 1'b0, 32'h0, 32'h0);
    chk("rst_halt_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_halt_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    step();
    step();
    chk_id("recap0", 1'b1, 32'h0, 32'h4);
    redirect_valid = 1'b1; redirect_target = 32'h3FC;
    step();
    chk_id("edge_redir", 1'b0, 32'h0, 32'h3FC);
    chk("edge_redir_fault", {31'd0, fetch_fault}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk_id("last_word", 1'b1, 32'h3FC, 32'h400);
    chk("last_plus4", id_pc_plus4, 32'h400);
    step();
    chk_id("over_limit", 1'b0, 32'h3FC, 32'h400);
    chk("over_fault", {31'd0, fetch_fault}, 32'd1);
    chk("over_halted", {31'd0, halted}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_target = 32'h400;
    step();
    chk("limit_tgt_add", inst_add, 32'h400);
    chk("limit_tgt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("limit_tgt_halted", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b0;
    reset2 = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lim_pc", id_pc2, 32'(i * 4));
      chk("lim_valid", {31'd0, id_valid2}, 32'd1);
      chk("lim_halted", {31'd0, halted2}, 32'd0);
      if (i == 3) id_ready2 = 1'b0;
      step();
    end
    chk("lim_hold_pc", id_pc2, 32'hC);
    chk("lim_hold_valid", {31'd0, id_valid2}, 32'd1);
    chk("lim_hold_halted", {31'd0, halted2}, 32'd0);
    chk("lim_hold_add", inst_add2, 32'h10);
    id_ready2 = 1'b1;
    step();
    chk("lim_valid_drop", {31'd0, id_valid2}, 32'd0);
    chk("lim_fault", {31'd0, fetch_fault2}, 32'd1);
    chk("lim_halted_end", {31'd0, halted2}, 32'd1);
    chk("lim_add_end", inst_add2, 32'h10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
